// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader and future memory-side blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package inst_loader_pkg;

    // Loader FSM encoding; values are fixed so other blocks can decode state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } ld_state_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/inst_loader_byte_packer.sv
// Packs a byte stream MSB-first into a 32-bit word; flags the 4th byte of each word.
// Latency: word updates on the edge that accepts a byte; last_byte is combinational.
// Backpressure: none; the parent gates shift_en with its own ready.
//
// Ports:
//   clk, rst_n      clock, async active-low reset
//   clr             synchronous clear of word and byte index
//   shift_en        accept din this cycle
//   din[7:0]        stream byte
//   word[31:0]      assembled word (byte 0 ends up in [31:24])
//   last_byte       shift_en while the byte index is 3
module inst_loader_byte_packer
    import inst_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        last_byte
);

    logic [1:0]  idx_q;
    logic [31:0] word_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= 2'd0;
            word_q <= 32'd0;
        end else if (clr) begin
            idx_q  <= 2'd0;
            word_q <= 32'd0;
        end else if (shift_en) begin
            // Shifting left means the first byte migrates to the top after four shifts.
            word_q <= {word_q[23:0], din};
            idx_q  <= idx_q + 2'd1;
        end
    end

    assign word      = word_q;
    assign last_byte = shift_en && (idx_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/inst_loader.sv
// Instruction-memory write engine: packs stream bytes into words and writes them at base, base+4, ...
// Latency: write strobe one cycle after the 4th byte; one DONE cycle after the last write.
// Backpressure: in_ready is high only in RECV (state decode), so producers stall during WRITE/IDLE/DONE.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   load_start/load_base/load_len  begin a load (sampled in IDLE only)
//   in_valid/in_data/in_ready      byte stream handshake
//   mem_we/mem_addr/mem_wdata      instruction memory word write port
//   busy, done, words_written      load status
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH-1:0] load_base,
    input  logic [LEN_WIDTH-1:0]  load_len,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  words_written
);

    ld_state_t             state_q, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_hold_q;
    logic [LEN_WIDTH-1:0]  len_q, words_q;
    logic [31:0]           wdata_hold_q;
    logic [31:0]           pk_word;
    logic                  pk_last;
    logic                  pk_shift;
    logic                  start_acc;

    assign start_acc = (state_q == IDLE) && load_start;
    assign pk_shift  = (state_q == RECV) && in_valid;

    inst_loader_byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (start_acc),
        .shift_en  (pk_shift),
        .din       (in_data),
        .word      (pk_word),
        .last_byte (pk_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (load_start) begin
                    state_nxt = (load_len == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                in_ready = 1'b1;
                if (pk_last) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                mem_we    = 1'b1;
                state_nxt = (LEN_WIDTH'(words_q + 1'b1) == len_q) ? DONE : RECV;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: working address/count, plus hold registers so the memory
    // port keeps showing the last written word while the next one assembles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q       <= '0;
            len_q        <= '0;
            words_q      <= '0;
            addr_hold_q  <= '0;
            wdata_hold_q <= 32'd0;
        end else if (start_acc) begin
            addr_q  <= load_base;
            len_q   <= load_len;
            words_q <= '0;
        end else if (state_q == WRITE) begin
            addr_q       <= addr_q + ADDR_WIDTH'(WORD_BYTES);
            words_q      <= words_q + 1'b1;
            addr_hold_q  <= addr_q;
            wdata_hold_q <= pk_word;
        end
    end

    assign mem_addr      = (state_q == WRITE) ? addr_q  : addr_hold_q;
    assign mem_wdata     = (state_q == WRITE) ? pk_word : wdata_hold_q;
    assign words_written = words_q;

endmodule

// File: doc/inst_loader.md
# inst_loader

Instruction-memory write engine for the multicycle processor. Accepts a byte stream over a valid/ready handshake, packs every four bytes MSB-first into a 32-bit instruction word, and issues one word write per instruction to the instruction memory at byte addresses base, base+4, base+8, and so on. It is the producer side of the word-indexed instruction store that the fetch stage reads. It runs before or between program executions, never concurrently with fetch.

## Interface
Parameters:
- ADDR_WIDTH, 24, width of the byte address driven to instruction memory
- DATA_WIDTH, 8, width of the incoming stream symbol; must be 8
- LEN_WIDTH, 8, width of the word-count input

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- load_start  in  1  one-cycle pulse that begins a load; sampled only in IDLE
- load_base  in  ADDR_WIDTH  first word byte address, captured on load_start
- load_len  in  LEN_WIDTH  number of 32-bit words to write, captured on load_start
- in_valid  in  1  byte available on in_data
- in_data  in  DATA_WIDTH  stream byte
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction-memory write strobe, one cycle per word
- mem_addr  out  ADDR_WIDTH  write byte address
- mem_wdata  out  32  packed instruction word
- busy  out  1  high from load_start acceptance until done
- done  out  1  one-cycle pulse when the last word has been written
- words_written  out  LEN_WIDTH  count of words written in the current or last load

## Operation
- States: IDLE, RECV, WRITE, DONE.
- IDLE: in_ready=0. load_start=1 captures load_base and load_len, clears words_written and the byte index, and sets busy. If load_len==0 the next state is DONE; otherwise it is RECV.
- RECV: in_ready=1. Each cycle with in_valid&&in_ready shifts in_data into the word register, MSB first: byte 0 goes to [31:24] and byte 3 goes to [7:0]. The byte index is 2 bits and wraps. Acceptance of byte 3 moves the state to WRITE.
- WRITE: in_ready=0. mem_we=1, mem_addr=current address, mem_wdata=assembled word. On exit the address increments by 4 (modulo 2^ADDR_WIDTH, so wrap is silent) and words_written increments by 1. If words_written+1==load_len the next state is DONE; otherwise it is RECV.
- DONE: done=1 for one cycle and busy=0 on exit. The next state is IDLE.
- load_start outside IDLE is ignored. in_valid outside RECV is ignored and no byte is consumed.
- Reset mid-load: all state clears immediately, a partial word is discarded, and no further mem_we is issued.
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, words_written=0, state=IDLE.
- mem_addr and mem_wdata hold their last values outside WRITE.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from in_valid to in_ready.
- load_start at edge N puts busy=1 and state=RECV after N, so in_ready=1 in cycle N+1.
- Accepting byte 3 at edge M gives mem_we=1 in cycle M+1, and in_ready=1 again in cycle M+2. Peak throughput is 4 bytes per 5 cycles.
- The last WRITE is followed by one DONE cycle. busy falls together with done deasserting, and load_start is accepted on the following edge.
- in_valid gaps (bubbles) are allowed anywhere in RECV with no effect other than delay.

## Structure
- A shared package (or `include` file) holds the state encoding localparams (IDLE=2'd0, RECV=2'd1, WRITE=2'd2, DONE=2'd3) and WORD_BYTES=4. These are shared with future memory-side blocks.
- The natural sub-module is byte_packer: the shift register plus the 2-bit byte index. Its outputs are word[31:0] and a last_byte strobe. Its inputs are shift_en and clr.

## Test plan
- Two-word load: load_base=0, load_len=2, bytes F4 11 30 05 F4 13 10 07 -> mem_we at addr 0 with data 0xF4113005, then at addr 4 with data 0xF4131007; done pulses once; words_written=2.
- Zero-length load: load_len=0 -> no mem_we; done pulses exactly 2 cycles after load_start; in_ready never asserts.
- Bubbles and backpressure: in_valid toggling 1,0,0,1 per cycle with base=0x10, len=1, bytes F2 33 10 0C -> a single write of 0xF233100C at 0x10; no byte lost or duplicated; in_ready=0 during WRITE.
- Address wrap: load_base=0xFFFFFC, len=2 -> writes at 0xFFFFFC, then 0x000000.
- Reset mid-word: assert rst_n=0 after 2 of 4 bytes -> all outputs go to their reset values asynchronously. A new load (base=0, len=1, bytes F1 31 50 02) then writes 0xF1315002 with no residue from the earlier partial word.
- load_start pulsed during RECV and DONE -> ignored; captured base and len unchanged; exactly load_len writes occur.
